alu_rs: RTL

ALU reservation station for the out-of-order core: a small collapsing issue queue between dispatch and the single-cycle ALU. It buffers dispatched integer, branch and jump micro-ops, and wakes waiting source operands by snooping the common data bus (CDB). Each cycle it selects the oldest entry whose operands are both ready and presents it to the ALU through a registered execute-stage bundle. A flush from the ROB discards all held and in-flight work.

---
 rtl/core_pkg.sv | 36 +++
 rtl/rs_select.sv | 34 +++
 rtl/alu_rs.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions used by the ALU reservation station and the ALU.
// - OPC_*      : RV32I major opcodes (instruction bits [6:2])
// - rs_tag_t   : ROB tag storage; wide enough for any ROB up to 256 entries,
//                narrower TAGW values are zero-extended into it
// - rs_entry_t : one reservation-station entry
package core_pkg;

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;

  localparam int unsigned RS_TAG_MAX_W = 8;

  typedef logic [RS_TAG_MAX_W-1:0] rs_tag_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] imm;
    logic [15:0] pc;
    rs_tag_t     rob_idx;
    logic        rs1_rdy;
    rs_tag_t     rs1_tag;
    logic [31:0] rs1_data;
    logic        rs2_rdy;
    rs_tag_t     rs2_tag;
    logic [31:0] rs2_data;
  } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Oldest-ready priority encoder for the reservation station.
// Entry 0 is the oldest, so the lowest index with valid && ready wins.
// - valid_i : per-entry valid bits
// - ready_i : per-entry "both operands ready" bits
// - found_o : some entry is selectable
// - idx_o   : index of the selected entry (0 when none)
module rs_select #(
  parameter int DEPTH = 4,
  parameter int IDXW  = 2
) (
  input  logic [DEPTH-1:0] valid_i,
  input  logic [DEPTH-1:0] ready_i,
  output logic             found_o,
  output logic [IDXW-1:0]  idx_o
);

  logic            hit;
  logic [IDXW-1:0] idx;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!hit && valid_i[i] && ready_i[i]) begin
        hit = 1'b1;
        idx = IDXW'(i);
      end
    end
  end

  assign found_o = hit;
  assign idx_o   = idx;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: collapsing issue queue between dispatch and the
// single-cycle ALU.
// - clk/rst           : core clock, asynchronous active-high reset
// - flush             : drop every held entry and the EXE register
// - dis_*             : dispatch request, operands and tags; dis_ready = room
// - cdb_*             : result broadcast used for operand wakeup
// - issue_ready       : ALU can accept the EXE bundle this cycle
// - EXE_*, alu_start  : registered issue bundle and its valid
// - occupancy         : number of valid entries
module alu_rs
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        dis_valid,
  output logic                        dis_ready,
  input  logic [4:0]                  dis_opcode,
  input  logic [2:0]                  dis_funct3,
  input  logic                        dis_funct7,
  input  logic [31:0]                 dis_imm,
  input  logic [15:0]                 dis_pc,
  input  logic [TAGW-1:0]             dis_rob_idx,
  input  logic                        dis_rs1_rdy,
  input  logic                        dis_rs2_rdy,
  input  logic [TAGW-1:0]             dis_rs1_tag,
  input  logic [TAGW-1:0]             dis_rs2_tag,
  input  logic [31:0]                 dis_rs1_data,
  input  logic [31:0]                 dis_rs2_data,
  input  logic                        cdb_valid,
  input  logic [TAGW-1:0]             cdb_rob_idx,
  input  logic [31:0]                 cdb_data,
  input  logic                        issue_ready,
  output logic [4:0]                  EXE_opcode,
  output logic [2:0]                  EXE_funct3,
  output logic                        EXE_funct7,
  output logic [31:0]                 EXE_imm,
  output logic [15:0]                 EXE_pc,
  output logic [31:0]                 EXE_rs1_data,
  output logic [31:0]                 EXE_rs2_data,
  output logic [TAGW-1:0]             EXE_rob_idx,
  output logic                        alu_start,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCCW = $clog2(DEPTH+1);

  rs_entry_t entries_q [DEPTH];
  rs_entry_t entries_d [DEPTH];
  // Stored entries with this cycle's wakeup applied; the extra top slot is
  // an always-empty entry shifted in when the queue collapses.
  rs_entry_t woken [DEPTH+1];
  rs_entry_t dis_entry;

  logic [OCCW-1:0] occ_q, occ_d;
  logic [OCCW-1:0] dis_slot;

  logic            alu_start_q, alu_start_d;
  logic [4:0]      exe_opcode_q, exe_opcode_d;
  logic [2:0]      exe_funct3_q, exe_funct3_d;
  logic            exe_funct7_q, exe_funct7_d;
  logic [31:0]     exe_imm_q, exe_imm_d;
  logic [15:0]     exe_pc_q, exe_pc_d;
  logic [31:0]     exe_rs1_data_q, exe_rs1_data_d;
  logic [31:0]     exe_rs2_data_q, exe_rs2_data_d;
  logic [TAGW-1:0] exe_rob_idx_q, exe_rob_idx_d;

  logic [DEPTH-1:0] valid_vec, ready_vec;
  logic             sel_found;
  logic [IDXW-1:0]  sel_idx;
  logic             exe_free, do_issue, do_dis;
  rs_tag_t          cdb_tag;

  assign cdb_tag   = rs_tag_t'(cdb_rob_idx);
  assign dis_ready = (occ_q < OCCW'(DEPTH));

  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      ready_vec[i] = entries_q[i].rs1_rdy && entries_q[i].rs2_rdy;
    end
  end

  rs_select #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_select (
    .valid_i (valid_vec),
    .ready_i (ready_vec),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  always_comb begin
    exe_free = !alu_start_q || issue_ready;
    do_issue = sel_found && exe_free;
    do_dis   = dis_valid && dis_ready;

    dis_entry          = '0;
    dis_entry.valid    = 1'b1;
    dis_entry.opcode   = dis_opcode;
    dis_entry.funct3   = dis_funct3;
    dis_entry.funct7   = dis_funct7;
    dis_entry.imm      = dis_imm;
    dis_entry.pc       = dis_pc;
    dis_entry.rob_idx  = rs_tag_t'(dis_rob_idx);
    dis_entry.rs1_rdy  = dis_rs1_rdy;
    dis_entry.rs1_tag  = rs_tag_t'(dis_rs1_tag);
    dis_entry.rs1_data = dis_rs1_data;
    dis_entry.rs2_rdy  = dis_rs2_rdy;
    dis_entry.rs2_tag  = rs_tag_t'(dis_rs2_tag);
    dis_entry.rs2_data = dis_rs2_data;
    if (cdb_valid && !dis_rs1_rdy && dis_entry.rs1_tag == cdb_tag) begin
      dis_entry.rs1_rdy  = 1'b1;
      dis_entry.rs1_data = cdb_data;
    end
    if (cdb_valid && !dis_rs2_rdy && dis_entry.rs2_tag == cdb_tag) begin
      dis_entry.rs2_rdy  = 1'b1;
      dis_entry.rs2_data = cdb_data;
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      woken[i] = entries_q[i];
      if (cdb_valid && entries_q[i].valid) begin
        if (!entries_q[i].rs1_rdy && entries_q[i].rs1_tag == cdb_tag) begin
          woken[i].rs1_rdy  = 1'b1;
          woken[i].rs1_data = cdb_data;
        end
        if (!entries_q[i].rs2_rdy && entries_q[i].rs2_tag == cdb_tag) begin
          woken[i].rs2_rdy  = 1'b1;
          woken[i].rs2_data = cdb_data;
        end
      end
    end
    woken[DEPTH] = '0;

    // The new op lands in the first free slot after the collapse, which is
    // one lower than the current occupancy when an entry issues.
    dis_slot = do_issue ? (occ_q - OCCW'(1)) : occ_q;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (do_issue && i >= 32'(sel_idx)) entries_d[i] = woken[i+1];
      else                               entries_d[i] = woken[i];
      if (do_dis && i == 32'(dis_slot))  entries_d[i] = dis_entry;
    end

    occ_d = occ_q + OCCW'(do_dis) - OCCW'(do_issue);

    alu_start_d    = alu_start_q;
    exe_opcode_d   = exe_opcode_q;
    exe_funct3_d   = exe_funct3_q;
    exe_funct7_d   = exe_funct7_q;
    exe_imm_d      = exe_imm_q;
    exe_pc_d       = exe_pc_q;
    exe_rs1_data_d = exe_rs1_data_q;
    exe_rs2_data_d = exe_rs2_data_q;
    exe_rob_idx_d  = exe_rob_idx_q;
    if (do_issue) begin
      alu_start_d    = 1'b1;
      exe_opcode_d   = entries_q[sel_idx].opcode;
      exe_funct3_d   = entries_q[sel_idx].funct3;
      exe_funct7_d   = entries_q[sel_idx].funct7;
      exe_imm_d      = entries_q[sel_idx].imm;
      exe_pc_d       = entries_q[sel_idx].pc;
      exe_rs1_data_d = entries_q[sel_idx].rs1_data;
      exe_rs2_data_d = entries_q[sel_idx].rs2_data;
      exe_rob_idx_d  = entries_q[sel_idx].rob_idx[TAGW-1:0];
    end else if (exe_free) begin
      alu_start_d = 1'b0;
    end

    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_d[i] = '0;
      occ_d          = '0;
      alu_start_d    = 1'b0;
      exe_opcode_d   = '0;
      exe_funct3_d   = '0;
      exe_funct7_d   = 1'b0;
      exe_imm_d      = '0;
      exe_pc_d       = '0;
      exe_rs1_data_d = '0;
      exe_rs2_data_d = '0;
      exe_rob_idx_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      occ_q          <= '0;
      alu_start_q    <= 1'b0;
      exe_opcode_q   <= '0;
      exe_funct3_q   <= '0;
      exe_funct7_q   <= 1'b0;
      exe_imm_q      <= '0;
      exe_pc_q       <= '0;
      exe_rs1_data_q <= '0;
      exe_rs2_data_q <= '0;
      exe_rob_idx_q  <= '0;
    end else begin
      entries_q      <= entries_d;
      occ_q          <= occ_d;
      alu_start_q    <= alu_start_d;
      exe_opcode_q   <= exe_opcode_d;
      exe_funct3_q   <= exe_funct3_d;
      exe_funct7_q   <= exe_funct7_d;
      exe_imm_q      <= exe_imm_d;
      exe_pc_q       <= exe_pc_d;
      exe_rs1_data_q <= exe_rs1_data_d;
      exe_rs2_data_q <= exe_rs2_data_d;
      exe_rob_idx_q  <= exe_rob_idx_d;
    end
  end

  assign alu_start    = alu_start_q;
  assign occupancy    = occ_q;
  assign EXE_opcode   = exe_opcode_q;
  assign EXE_funct3   = exe_funct3_q;
  assign EXE_funct7   = exe_funct7_q;
  assign EXE_imm      = exe_imm_q;
  assign EXE_pc       = exe_pc_q;
  assign EXE_rs1_data = exe_rs1_data_q;
  assign EXE_rs2_data = exe_rs2_data_q;
  assign EXE_rob_idx  = exe_rob_idx_q;

endmodule
